// File: rtl/fetch_queue.sv
// Instruction prefetch queue: circular buffer of {pc, instr} pairs between fetch and decode.
// Latency: 1 cycle push-to-output, with no combinational path from in_* to out_*.
// Backpressure: in_ready drops only when full, independent of out_ready; NOP/pc 0 are shown while empty.
module fetch_queue #(
    parameter int          DEPTH = 4,
    parameter int          AW    = 2,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic [AW:0]   count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q,  count_d;
    logic            push, pop;
    entry_t          head;

    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];
    assign out_pc    = out_valid ? head.pc    : 32'h0;
    assign out_instr = out_valid ? head.instr : NOP;

    always_comb begin
        push     = in_valid & in_ready & ~flush;
        pop      = out_valid & out_ready & ~flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is deliberately left out of reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed test-plan steps plus random traffic against a queue-based model.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam int          AW    = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_instr, out_pc, out_instr;
    logic [AW:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] model_q[$];
    logic [31:0] popped_q[$];

    fetch_queue #(.DEPTH(DEPTH), .AW(AW), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] h;
        h = (model_q.size() != 0) ? model_q[0] : {32'h0, NOP};
        chk("count",     32'(count),     32'(model_q.size()));
        chk("in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        chk("out_pc",    out_pc,         h[63:32]);
        chk("out_instr", out_instr,      h[31:0]);
    endtask

    // One clock cycle: drive inputs, advance the model across the edge, check outputs after it.
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
        logic do_push, do_pop;
        rst = r; flush = f; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
        do_push = iv && (model_q.size() != DEPTH) && !f;
        do_pop  = ordy && (model_q.size() != 0) && !f;
        if (out_valid && ordy && !f && !r) popped_q.push_back(out_instr);
        @(posedge clk);
        if (r || f) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({pc, ins});
        end
        #1;
        check_outputs();
    endtask

    initial begin
        logic [31:0] exp_seq[6];
        int          bi;
        int          guard;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;

        // Reset, then idle
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_instr", out_instr, NOP);
        cyc(0, 0, 0, 0, 0, 0);

        // Fill with no pops, then a fifth push that must be refused
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 32'(i * 4), 32'hA0000001 + 32'(i), 0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_head", out_instr, 32'hA0000001);
        cyc(0, 0, 1, 32'h10, 32'hA0000005, 0);
        chk("full_hold", 32'(count), 32'd4);

        // Drain across the wrap while pushing B1, B2 as room opens
        popped_q.delete();
        bi = 0;
        guard = 0;
        while ((bi < 2 || model_q.size() != 0) && guard < 20) begin
            if (bi < 2) begin
                logic acc;
                acc = (model_q.size() != DEPTH);
                cyc(0, 0, 1, 32'h20 + 32'(bi * 4), 32'hB0000001 + 32'(bi), 1);
                if (acc) bi++;
            end else begin
                cyc(0, 0, 0, 0, 0, 1);
            end
            guard++;
        end
        chk("drain_bound", 32'(guard < 20), 32'd1);
        exp_seq = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004,
                    32'hB0000001, 32'hB0000002};
        chk("drain_len", 32'(popped_q.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            chk("drain_seq", (i < popped_q.size()) ? popped_q[i] : 32'hx, exp_seq[i]);

        // Streaming push+pop for 20 cycles
        popped_q.delete();
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1, 32'(i * 4), 32'hC0000000 + 32'(i), 1);
            chk("stream_count", 32'(count), 32'd1);
        end
        cyc(0, 0, 0, 0, 0, 1);
        chk("stream_len", 32'(popped_q.size()), 32'd20);
        for (int i = 0; i < 20; i++)
            chk("stream_seq", (i < popped_q.size()) ? popped_q[i] : 32'hx, 32'hC0000000 + 32'(i));

        // Flush with simultaneous traffic
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h30 + 32'(i * 4), 32'hD1000000 + 32'(i), 0);
        chk("pre_flush", 32'(count), 32'd3);
        cyc(0, 1, 1, 32'h3C, 32'hDEADBEEF, 1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_instr", out_instr, NOP);
        cyc(0, 0, 1, 32'h40, 32'hD0000001, 0);
        chk("post_flush_pc", out_pc, 32'h40);
        chk("post_flush_instr", out_instr, 32'hD0000001);
        cyc(0, 0, 0, 0, 0, 1);

        // Reset mid-operation
        cyc(0, 0, 1, 32'h50, 32'hE1000001, 0);
        cyc(0, 0, 1, 32'h54, 32'hE1000002, 0);
        chk("pre_rst", 32'(count), 32'd2);
        cyc(1, 0, 1, 32'h58, 32'hE1000003, 1);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_pc", out_pc, 32'h0);
        cyc(0, 0, 1, 32'h80, 32'hE0000001, 0);
        chk("post_rst_pc", out_pc, 32'h80);
        chk("post_rst_instr", out_instr, 32'hE0000001);
        cyc(0, 0, 0, 0, 0, 1);
        chk("post_rst_empty", out_instr, NOP);

        // Random traffic, including flush/reset with traffic and reset+flush together
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(15) == 0),
                ($urandom_range(3) != 0), $urandom, $urandom, ($urandom_range(2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
